// File: rtl/mips_pc_pkg.sv
// Shared types and constants for the MIPS fetch-stage PC sequencer.
// Contents:
//   pc_state_e - sequencer FSM states
//   redir_e    - source of the next PC value (none = PC+4, exception, branch, jump)
//   PC_INC     - sequential PC increment
//   WAIT_W     - width of the imem_ack wait counter
package mips_pc_pkg;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD
  } pc_state_e;

  typedef enum logic [1:0] {
    NONE,
    EXC,
    BR,
    JMP
  } redir_e;

  localparam logic [31:0] PC_INC = 32'd4;
  localparam int unsigned WAIT_W = 8;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational select of the next PC value.
// Optional build macro: ALIGN_CHECK_EN
//   defined   - a branch/jump target with [1:0] != 0 raises align_err and selects EXC_VECTOR
//   undefined - target bits [1:0] are forced to zero, align_err stays low
// Ports:
//   boot      in   first cycle after reset, selects RESET_VECTOR
//   src       in   next-PC source (NONE = PC+4, EXC, BR, JMP)
//   target    in   redirect target used for BR/JMP
//   pc_cur    in   current PC
//   pc_next   out  selected next PC
//   align_err out  misaligned redirect target detected
module pc_next_mux
  import mips_pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        boot,
  input  redir_e      src,
  input  logic [31:0] target,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        align_err
);

  always_comb begin
    align_err = 1'b0;
    pc_next   = pc_cur + PC_INC;
    if (boot) begin
      pc_next = RESET_VECTOR;
    end else begin
      unique case (src)
        EXC: pc_next = EXC_VECTOR;
        BR, JMP: begin
`ifdef ALIGN_CHECK_EN
          if (target[1:0] != 2'b00) begin
            align_err = 1'b1;
            pc_next   = EXC_VECTOR;
          end else begin
            pc_next = target;
          end
`else
          pc_next = target & ~32'h3;
`endif
        end
        default: pc_next = pc_cur + PC_INC;  // wraps modulo 2^32
      endcase
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Sequencer for the fetch-stage PC register: drives its enable/next value, runs the
// instruction-memory req/ack handshake, arbitrates redirects (exception > branch > jump >
// PC+4), holds one pending redirect across stalls and flushes IF/ID on every redirect.
// Optional build macro: ALIGN_CHECK_EN (misaligned redirect targets become exceptions).
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   pc_cur                in  32   PC register output
//   pc_en, pc_next        out      PC register enable / next value
//   imem_req, imem_addr   out      fetch request (held until ack) / address (= pc_cur)
//   imem_ack              in       fetch data valid
//   stall                 in       hazard-unit stall
//   exc                   in       exception pulse from later stages
//   branch_taken/_target  in       resolved taken branch
//   jump/jump_target      in       jump request
//   flush                 out      registered one-cycle IF/ID kill
//   fetch_err             out      registered one-cycle fetch-error pulse
//   epc                   out  32  PC captured on exception, timeout or misalignment
module pc_fetch_ctrl
  import mips_pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
  parameter int unsigned MAX_WAIT     = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_cur,
  output logic        pc_en,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        exc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        flush,
  output logic        fetch_err,
  output logic [31:0] epc
);

  localparam logic [WAIT_W-1:0] MaxWaitCnt = WAIT_W'(MAX_WAIT);

  pc_state_e         state_q, state_d;
  redir_e            pend_src_q, pend_src_d;
  logic [31:0]       pend_tgt_q, pend_tgt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              drop_q, drop_d;
  logic              flush_q, flush_d;
  logic              fetch_err_q, fetch_err_d;
  logic [31:0]       epc_q, epc_d;

  redir_e      live_src, sel_src;
  logic [31:0] live_tgt, sel_tgt;
  logic        req, take_exc, timeout, advance, use_redir, align_err;

  // Request is suppressed for one cycle after an exception or timeout redirect.
  assign req       = (state_q == FETCH) && !drop_q;
  assign take_exc  = (state_q != BOOT) && exc;
  assign timeout   = req && !imem_ack && (wait_cnt_q == MaxWaitCnt);
  assign advance   = !take_exc &&
                     ((req && imem_ack && !stall) || ((state_q == HOLD) && !stall));
  assign use_redir = advance && ((sel_src == BR) || (sel_src == JMP));

  assign imem_req  = req;
  assign imem_addr = pc_cur;
  assign flush     = flush_q;
  assign fetch_err = fetch_err_q;
  assign epc       = epc_q;

  always_comb begin
    live_src = NONE;
    live_tgt = jump_target;
    if (branch_taken) begin
      live_src = BR;
      live_tgt = branch_target;
    end else if (jump) begin
      live_src = JMP;
    end

    // A redirect arriving in the same cycle as the advance beats the held one.
    sel_src = pend_src_q;
    sel_tgt = pend_tgt_q;
    if (take_exc || timeout) begin
      sel_src = EXC;
    end else if (live_src != NONE) begin
      sel_src = live_src;
      sel_tgt = live_tgt;
    end
  end

  pc_next_mux #(
    .RESET_VECTOR (RESET_VECTOR),
    .EXC_VECTOR   (EXC_VECTOR)
  ) u_next_mux (
    .boot      (state_q == BOOT),
    .src       (sel_src),
    .target    (sel_tgt),
    .pc_cur    (pc_cur),
    .pc_next   (pc_next),
    .align_err (align_err)
  );

  always_comb begin
    state_d     = state_q;
    pend_src_d  = pend_src_q;
    pend_tgt_d  = pend_tgt_q;
    drop_d      = 1'b0;
    flush_d     = 1'b0;
    fetch_err_d = 1'b0;
    epc_d       = epc_q;
    pc_en       = 1'b0;

    if (state_q == BOOT) begin
      // Gated so the register stays disabled while reset is asserted.
      pc_en   = rst_n;
      state_d = FETCH;
    end else if (take_exc || timeout) begin
      pc_en       = 1'b1;
      flush_d     = 1'b1;
      fetch_err_d = timeout && !take_exc;
      epc_d       = pc_cur;
      drop_d      = 1'b1;
      pend_src_d  = NONE;
      state_d     = FETCH;
    end else if (advance) begin
      pc_en      = 1'b1;
      pend_src_d = NONE;
      state_d    = FETCH;
      if (use_redir) begin
        flush_d = 1'b1;
        if (align_err) begin
          fetch_err_d = 1'b1;
          epc_d       = sel_tgt;
        end
      end
    end else begin
      if (live_src != NONE) begin
        pend_src_d = live_src;
        pend_tgt_d = live_tgt;
      end
      if (req && imem_ack) begin
        state_d = HOLD;
      end
    end

    wait_cnt_d = (req && !imem_ack && !pc_en) ? wait_cnt_q + WAIT_W'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      pend_src_q  <= NONE;
      pend_tgt_q  <= '0;
      wait_cnt_q  <= '0;
      drop_q      <= 1'b0;
      flush_q     <= 1'b0;
      fetch_err_q <= 1'b0;
      epc_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_src_q  <= pend_src_d;
      pend_tgt_q  <= pend_tgt_d;
      wait_cnt_q  <= wait_cnt_d;
      drop_q      <= drop_d;
      flush_q     <= flush_d;
      fetch_err_q <= fetch_err_d;
      epc_q       <= epc_d;
    end
  end

endmodule
